// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the two-master memory arbiter:
//                ownership FSM encoding, default memory depth, word width and
//                the address range check used for every master.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int c_addr_words = 1024;  // default shared memory depth (words)
  localparam int c_data_w     = 32;    // memory word width

  // Ownership state: IDLE means nobody holds the port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // A byte address is usable only if it is word aligned and every bit above
  // the word index is zero.
  function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
    return ((addr >> (aw + 2)) == 32'd0) && (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of both master ports and the memory port of the
//                arbiter.
//  Ports       : m0_*/m1_* : req, we, lock, addr, wdata (master -> arbiter)
//                            gnt, rvalid, rdata, err (arbiter -> master)
//                mem_*     : we, addr, wdata (arbiter -> memory)
//                            rdata (memory -> arbiter)
//                modport slave  : arbiter view
//                modport master : masters + memory model view
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
  parameter int AW = 10
) ();
  import mem_pkg::*;

  logic                m0_req;
  logic                m0_we;
  logic                m0_lock;
  logic [31:0]         m0_addr;
  logic [c_data_w-1:0] m0_wdata;
  logic                m0_gnt;
  logic                m0_rvalid;
  logic [c_data_w-1:0] m0_rdata;
  logic                m0_err;

  logic                m1_req;
  logic                m1_we;
  logic                m1_lock;
  logic [31:0]         m1_addr;
  logic [c_data_w-1:0] m1_wdata;
  logic                m1_gnt;
  logic                m1_rvalid;
  logic [c_data_w-1:0] m1_rdata;
  logic                m1_err;

  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [c_data_w-1:0] mem_wdata;
  logic [c_data_w-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick2
//  Description : Two-way round-robin picker. A lone requester wins; on a tie
//                the master that was not granted last wins.
//  Ports       : i_req0, i_req1 : request lines
//                i_last         : index of the master granted last
//                o_pick0/1      : one-hot pick (both 0 when nobody requests)
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick2 (
  input  wire logic i_req0,
  input  wire logic i_req1,
  input  wire logic i_last,
  output logic      o_pick0,
  output logic      o_pick1
);

  assign o_pick0 = i_req0 & (~i_req1 |  i_last);
  assign o_pick1 = i_req1 & (~i_req0 | ~i_last);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates two masters onto one single-port data memory.
//                Round-robin among unlocked beats, with locked bursts that
//                are capped at MAX_BURST beats. Read data and range errors
//                are returned one cycle after the grant.
//  Ports       : clk   : clock, rising edge
//                reset : synchronous, active-low
//                bus   : mem_arbiter_if.slave (both masters + memory port)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WORDS = c_addr_words,
  parameter int MAX_BURST  = 16
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mem_arbiter_if.slave  bus
);

  localparam int         AW           = $clog2(ADDR_WORDS);
  localparam logic [7:0] c_max_burst  = 8'(MAX_BURST);
  // A one-beat cap means a locked entry beat already exhausts the burst.
  localparam logic       c_single     = (MAX_BURST == 1);

  arb_state_t r_state, w_state_nxt;
  logic       r_last, w_last_nxt;
  logic [7:0] r_burst, w_burst_nxt;
  logic [7:0] w_burst_inc;

  logic w_pick0, w_pick1;
  logic w_gnt0, w_gnt1, w_any_gnt;
  logic w_ok0, w_ok1;
  logic w_rd0, w_rd1;

  logic [AW-1:0]       w_sel_addr;
  logic [c_data_w-1:0] w_sel_wdata;

  logic                r_rvalid0, r_rvalid1;
  logic                r_err0, r_err1;
  logic [c_data_w-1:0] r_rdata0, r_rdata1;
  logic [AW-1:0]       r_mem_addr;
  logic [c_data_w-1:0] r_mem_wdata;

  rr_pick2 u_pick (
    .i_req0  (bus.m0_req),
    .i_req1  (bus.m1_req),
    .i_last  (r_last),
    .o_pick0 (w_pick0),
    .o_pick1 (w_pick1)
  );

  assign w_ok0       = addr_in_range(bus.m0_addr, AW);
  assign w_ok1       = addr_in_range(bus.m1_addr, AW);
  assign w_burst_inc = r_burst + 8'd1;

  // Grant and next-state logic. Grants are forced low while reset is held so
  // nothing touches memory during reset.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_burst_nxt = r_burst;
    if (reset) begin
      case (r_state)
        IDLE: begin
          w_gnt0 = w_pick0;
          w_gnt1 = w_pick1;
          if (w_gnt0) begin
            if (bus.m0_lock && !c_single) begin
              w_state_nxt = OWN0;
              w_burst_nxt = 8'd1;  // entry beat counts toward the cap
            end else begin
              w_last_nxt = 1'b0;
            end
          end else if (w_gnt1) begin
            if (bus.m1_lock && !c_single) begin
              w_state_nxt = OWN1;
              w_burst_nxt = 8'd1;
            end else begin
              w_last_nxt = 1'b1;
            end
          end
        end
        OWN0: begin
          w_gnt0 = bus.m0_req;
          if (w_gnt0) begin
            if (!bus.m0_lock || (w_burst_inc == c_max_burst)) begin
              w_state_nxt = IDLE;
              w_last_nxt  = 1'b0;
              w_burst_nxt = 8'd0;
            end else begin
              w_burst_nxt = w_burst_inc;
            end
          end
        end
        OWN1: begin
          w_gnt1 = bus.m1_req;
          if (w_gnt1) begin
            if (!bus.m1_lock || (w_burst_inc == c_max_burst)) begin
              w_state_nxt = IDLE;
              w_last_nxt  = 1'b1;
              w_burst_nxt = 8'd0;
            end else begin
              w_burst_nxt = w_burst_inc;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_burst_nxt = 8'd0;
        end
      endcase
    end
  end

  assign w_any_gnt   = w_gnt0 | w_gnt1;
  assign w_sel_addr  = w_gnt1 ? bus.m1_addr[AW+1:2] : bus.m0_addr[AW+1:2];
  assign w_sel_wdata = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
  assign w_rd0       = w_gnt0 & ~bus.m0_we & w_ok0;
  assign w_rd1       = w_gnt1 & ~bus.m1_we & w_ok1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_burst     <= 8'd0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_burst   <= w_burst_nxt;
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      r_err0    <= w_gnt0 & ~w_ok0;
      r_err1    <= w_gnt1 & ~w_ok1;
      if (w_rd0) r_rdata0 <= bus.mem_rdata;
      if (w_rd1) r_rdata1 <= bus.mem_rdata;
      // Remember the last driven address/data so the memory port holds
      // steady instead of dropping to zero between grants.
      if (w_any_gnt) begin
        r_mem_addr  <= w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
      end
    end
  end

  assign bus.m0_gnt    = w_gnt0;
  assign bus.m1_gnt    = w_gnt1;
  assign bus.m0_rvalid = r_rvalid0;
  assign bus.m1_rvalid = r_rvalid1;
  assign bus.m0_rdata  = r_rdata0;
  assign bus.m1_rdata  = r_rdata1;
  assign bus.m0_err    = r_err0;
  assign bus.m1_err    = r_err1;

  // Out-of-range writes are granted but never reach the memory.
  assign bus.mem_we    = (w_gnt0 & bus.m0_we & w_ok0) | (w_gnt1 & bus.m1_we & w_ok1);
  assign bus.mem_addr  = w_any_gnt ? w_sel_addr  : r_mem_addr;
  assign bus.mem_wdata = w_any_gnt ? w_sel_wdata : r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A driver applies
//                directed beats and checks grants; expected responses go
//                into a queue that a monitor drains on rvalid/err.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(10)) bus ();

  mem_arbiter #(.ADDR_WORDS(1024), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Memory model: combinational read, write on rising edge; contents are
  // seeded on the first edge.
  logic [31:0] mem [0:1023];
  logic        init_done = 1'b0;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'h0BAD_C0DE;
      4:       return 32'hDEAD_BEEF;
      8:       return 32'h1111_2222;
      1023:    return 32'h5A5A_A5A5;
      default: return 32'(i) ^ 32'h1000_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
      init_done <= 1'b1;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t q[$];
  rsp_t pend[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic set_m(input int m, input logic req, we, lock,
                       input logic [31:0] addr, wdata);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_we = we; bus.m0_lock = lock;
      bus.m0_addr = addr; bus.m0_wdata = wdata;
    end else begin
      bus.m1_req = req; bus.m1_we = we; bus.m1_lock = lock;
      bus.m1_addr = addr; bus.m1_wdata = wdata;
    end
  endtask

  task automatic expect_rsp(input int m, input bit err, input logic [31:0] data);
    rsp_t r;
    r.m = m; r.err = err; r.data = data;
    pend.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Wait to the middle of the cycle and check the grant/strobe vector.
  task automatic at_neg(input logic eg0, eg1, ewe, input string name);
    @(negedge clk);
    checks++;
    if ({bus.m0_gnt, bus.m1_gnt, bus.mem_we} !== {eg0, eg1, ewe}) begin
      failures++;
      $display("FAIL %s gnt0,gnt1,mem_we got=%b%b%b expected=%b%b%b", name,
               bus.m0_gnt, bus.m1_gnt, bus.mem_we, eg0, eg1, ewe);
    end
  endtask

  // Advance past the edge; expectations for beats granted at that edge
  // become due in the following cycle.
  task automatic next();
    @(posedge clk);
    #1;
    while (pend.size() > 0) q.push_back(pend.pop_front());
  endtask

  // Monitor: every presented response must match the head of the queue.
  always @(negedge clk) begin
    if (bus.m0_rvalid | bus.m0_err | bus.m1_rvalid | bus.m1_err) begin
      rsp_t e;
      int   gm;
      logic grv, gerr;
      logic [31:0] gd;
      checks++;
      gm   = (bus.m1_rvalid | bus.m1_err) ? 1 : 0;
      grv  = gm ? bus.m1_rvalid : bus.m0_rvalid;
      gerr = gm ? bus.m1_err    : bus.m0_err;
      gd   = gm ? bus.m1_rdata  : bus.m0_rdata;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rsp m=%0d rvalid=%b err=%b data=%h expected none",
                 gm, grv, gerr, gd);
      end else begin
        e = q.pop_front();
        if ((gm != e.m) || (gerr !== e.err) || (grv !== !e.err) ||
            ((bus.m0_rvalid | bus.m0_err) && (bus.m1_rvalid | bus.m1_err)) ||
            (!e.err && (gd !== e.data))) begin
          failures++;
          $display("FAIL rsp got m=%0d rvalid=%b err=%b data=%h expected m=%0d err=%b data=%h",
                   gm, grv, gerr, gd, e.m, e.err, e.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    set_m(0, 1, 0, 0, 32'h10, 32'h0);
    set_m(1, 1, 0, 0, 32'h20, 32'h0);

    // Reset: grants forced off, then registered outputs cleared.
    at_neg(0, 0, 0, "rst_gnt_forced");
    next();
    at_neg(0, 0, 0, "rst_gnt_forced2");
    chk("rst_m0_rvalid", 32'(bus.m0_rvalid), 0);
    chk("rst_m1_err",    32'(bus.m1_err),    0);
    chk("rst_m0_rdata",  bus.m0_rdata,       0);
    chk("rst_mem_addr",  32'(bus.mem_addr),  0);
    chk("rst_mem_wdata", bus.mem_wdata,      0);
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    next();
    reset = 1'b1;

    // Single read of word 4.
    set_m(0, 1, 0, 0, 32'h10, 32'h0);
    expect_rsp(0, 0, 32'hDEAD_BEEF);
    at_neg(1, 0, 0, "single_rd");
    chk("single_rd_addr", 32'(bus.mem_addr), 4);
    next();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    at_neg(0, 0, 0, "idle");
    chk("mem_addr_hold", 32'(bus.mem_addr), 4);
    next();
    at_neg(0, 0, 0, "idle2");
    chk("rdata_hold",  bus.m0_rdata,       32'hDEAD_BEEF);
    chk("rvalid_drop", 32'(bus.m0_rvalid), 0);
    next();

    // Fresh reset, then tie alternation m0, m1, m0, m1.
    reset = 1'b0;
    at_neg(0, 0, 0, "rst2");
    next();
    reset = 1'b1;
    set_m(0, 1, 0, 0, 32'h10, 32'h0);
    set_m(1, 1, 0, 0, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) expect_rsp(0, 0, 32'hDEAD_BEEF);
      else            expect_rsp(1, 0, 32'h1111_2222);
      at_neg(i % 2 == 0, i % 2 == 1, 0, "tie");
      next();
    end
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);

    // Write word 16, then read it back.
    set_m(0, 1, 1, 0, 32'h40, 32'hCAFE_F00D);
    at_neg(1, 0, 1, "wr");
    chk("wr_wdata", bus.mem_wdata,      32'hCAFE_F00D);
    chk("wr_addr",  32'(bus.mem_addr),  16);
    next();
    set_m(0, 1, 0, 0, 32'h40, 32'h0);
    expect_rsp(0, 0, 32'hCAFE_F00D);
    at_neg(1, 0, 0, "rdback");
    next();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);

    // Lock: m1 holds three write beats while m0 waits.
    set_m(1, 1, 1, 1, 32'h50, 32'hA000_0000);
    at_neg(0, 1, 1, "lock_b1");
    next();
    set_m(0, 1, 0, 0, 32'h10, 32'h0);
    set_m(1, 1, 1, 1, 32'h54, 32'hA000_0001);
    at_neg(0, 1, 1, "lock_b2");
    next();
    set_m(1, 1, 1, 0, 32'h58, 32'hA000_0002);
    at_neg(0, 1, 1, "lock_b3");
    next();
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    expect_rsp(0, 0, 32'hDEAD_BEEF);
    at_neg(1, 0, 0, "lock_m0_after");
    next();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);

    // Burst cap of 4 with m0 lock held high and m1 waiting.
    set_m(0, 1, 0, 1, 32'h50, 32'h0);
    expect_rsp(0, 0, 32'hA000_0000);
    at_neg(1, 0, 0, "cap_b1");
    next();
    set_m(1, 1, 0, 0, 32'h54, 32'h0);
    for (int i = 2; i <= 4; i++) begin
      expect_rsp(0, 0, 32'hA000_0000);
      at_neg(1, 0, 0, "cap_beat");
      next();
    end
    expect_rsp(1, 0, 32'hA000_0001);
    at_neg(0, 1, 0, "cap_m1");
    next();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);

    // Out of range write (aliases word 0) must not modify memory.
    set_m(1, 1, 1, 0, 32'h1000, 32'hBAD0_BAD0);
    expect_rsp(1, 1, 32'h0);
    at_neg(0, 1, 0, "oor_wr");
    next();
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    set_m(0, 1, 0, 0, 32'h0, 32'h0);
    expect_rsp(0, 0, 32'h0BAD_C0DE);
    at_neg(1, 0, 0, "mem0_unchanged");
    next();
    set_m(0, 1, 0, 0, 32'h11, 32'h0);
    expect_rsp(0, 1, 32'h0);
    at_neg(1, 0, 0, "misaligned");
    next();
    set_m(0, 1, 0, 0, 32'hFFC, 32'h0);
    expect_rsp(0, 0, 32'h5A5A_A5A5);
    at_neg(1, 0, 0, "last_word");
    next();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);

    // Reset in the middle of an m0 locked burst.
    set_m(0, 1, 0, 1, 32'h10, 32'h0);
    expect_rsp(0, 0, 32'hDEAD_BEEF);
    at_neg(1, 0, 0, "rb_b1");
    next();
    reset = 1'b0;
    at_neg(0, 0, 0, "rb_in_reset");
    next();
    reset = 1'b1;
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    at_neg(0, 0, 0, "rb_after");
    chk("rb_no_rvalid", 32'(bus.m0_rvalid), 0);
    next();
    set_m(0, 1, 0, 0, 32'h10, 32'h0);
    set_m(1, 1, 0, 0, 32'h20, 32'h0);
    expect_rsp(0, 0, 32'hDEAD_BEEF);
    at_neg(1, 0, 0, "rb_tie_m0");
    next();
    expect_rsp(1, 0, 32'h1111_2222);
    at_neg(0, 1, 0, "rb_tie_m1");
    next();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);

    at_neg(0, 0, 0, "drain");
    next();
    at_neg(0, 0, 0, "drain2");
    chk("queue_empty", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_WORDS, 1024, depth of shared data memory in 32-bit words; index width AW = log2(ADDR_WORDS).
REQ-002 Parameter: MAX_BURST, 16, max consecutive locked beats one master may hold (range 1..255).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; 0 sampled at a rising edge resets the block.
REQ-005 mN_req  in  1  master N (N=0,1) requests one access.
REQ-006 mN_we  in  1  1 = write, 0 = read.
REQ-007 mN_lock  in  1  keep ownership after this beat.
REQ-008 mN_addr  in  32  byte address; word index = mN_addr[AW+1:2].
REQ-009 mN_wdata  in  32  write data.
REQ-010 mN_gnt  out  1  beat accepted this cycle (combinational).
REQ-011 mN_rvalid  out  1  registered read response valid.
REQ-012 mN_rdata  out  32  registered read data.
REQ-013 mN_err  out  1  registered one-cycle pulse: accepted beat was out of range.
REQ-014 mem_we  out  1  write strobe to memory.
REQ-015 mem_addr  out  AW  word index to memory.
REQ-016 mem_wdata  out  32  write data to memory.
REQ-017 mem_rdata  in  32  combinational read data from memory.

Function
REQ-018 Master holds req/we/lock/addr/wdata stable from req rise until the cycle its gnt=1.
REQ-019 At most one gnt asserted per cycle; a granted beat occupies the memory port in that same cycle.
REQ-020 FSM states: IDLE (no owner), OWN0, OWN1.
REQ-021 IDLE: one requester -> grant it; both -> grant the one not granted last (last_grant resets to 1, so master 0 wins first tie).
REQ-022 IDLE -> OWNn when master n is granted with mN_lock=1; otherwise remain IDLE and set last_grant=n.
REQ-023 OWNn: only master n may be granted; the other master's gnt is 0 even if requesting.
REQ-024 OWNn -> IDLE when master n is granted with lock=0, or when burst count reaches MAX_BURST; last_grant=n on exit.
REQ-025 OWNn with mN_req=0: no grant, burst counter holds, state holds.
REQ-026 Burst counter: cleared on entering OWNn, +1 per granted beat counting the entry beat; release happens on the beat that makes it MAX_BURST.
REQ-027 Out of range: mN_addr[31:AW+2] != 0 or mN_addr[1:0] != 0; the beat is still granted, mem_we forced 0, mN_err pulses next cycle, mN_rvalid stays 0.
REQ-028 Granted in-range read: next cycle mN_rvalid=1 and mN_rdata=mem_rdata captured at grant; latency exactly 1.
REQ-029 Granted write: mem_we=1 in grant cycle; no rvalid; mN_err=0.
REQ-030 Outputs when no grant: mem_we=0; mem_addr/mem_wdata hold their last value (no glitch to 0).
REQ-031 mN_rdata holds last value while mN_rvalid=0.
REQ-032 Back-to-back grants to either master permitted every cycle; responses pipelined, one per cycle.

Reset
REQ-033 reset=0 at an edge: state=IDLE, last_grant=1, burst count=0, all rvalid/err=0, rdata=0, mem_addr=0, mem_wdata=0.
REQ-034 During reset=0, all gnt=0 and mem_we=0 combinationally.
REQ-035 Reset mid-burst or with a read outstanding: ownership dropped, pending response discarded (no rvalid after release).

Structure
REQ-036 Shared package mem_pkg: FSM state enum (IDLE, OWN0, OWN1), ADDR_WORDS default, word width 32.
REQ-037 One sub-module: rr_pick2 (2-way round-robin picker: two reqs + last_grant -> one-hot pick).

Verification
REQ-038 Single read: m0 read addr 0x0000_0010, mem word 4 = 0xDEADBEEF -> m0_gnt same cycle, m0_rvalid=1, m0_rdata=0xDEADBEEF next cycle.
REQ-039 Tie: both req from IDLE after reset, unlocked -> grants m0, m1, m0, m1 on consecutive cycles.
REQ-040 Lock: m1 locked 3 beats (lock=0 on 3rd) while m0 requests -> m1 gnt 3 cycles, m0 gnt 4th cycle.
REQ-041 Starvation cap: MAX_BURST=4, m0 lock held high continuously, m1 requesting -> m0 gets 4 beats, then m1 granted.
REQ-042 Range: m1 write addr 0x0000_1000 (ADDR_WORDS=1024) -> gnt=1, mem_we=0, m1_err pulse next cycle, memory unchanged.
REQ-043 Reset mid-burst: reset=0 during OWN0 with a read granted -> no m0_rvalid after, state IDLE, next tie grants m0.
